// File: rtl/datamemory_sized_if.sv
// Request/response bus between the datapath and datamemory_sized.
// master drives requests and store data; slave returns load data and status.
`timescale 1ns/1ps
interface datamemory_sized_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              memread;
    logic              memwrite;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              rvalid;
    logic              ready;
    logic              err;

    modport master (
        output memread, memwrite, size, sign_ext, address, writedata,
        input  readdata, rvalid, ready, err
    );

    modport slave (
        input  memread, memwrite, size, sign_ext, address, writedata,
        output readdata, rvalid, ready, err
    );
endinterface

// File: rtl/datamemory_sized.sv
// Sized data memory for the KGP-RISC datapath: byte..doubleword lanes,
// registered sign/zero-extended loads, misalignment rejection, clear sweep.
`timescale 1ns/1ps
module datamemory_sized #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    datamemory_sized_if.slave   bus
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;
    localparam logic [0:0] S_RST   = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    logic [0:0]        state;
    logic [IW-1:0]     clr_ptr;
    logic              ready_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IW-1:0]     idx;
    logic [LB-1:0]     ofs;
    logic [3:0]        nbytes;
    logic              misaligned, illegal, bad, collide;
    logic              do_wr, do_rd, rej;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rdata_p0, rdata_p1;
    logic              vld_p1, err_p1;
    logic              unused_addr;

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    lane_mask = NB'(1);
            2'd1:    lane_mask = NB'(3);
            2'd2:    lane_mask = NB'(15);
            default: lane_mask = NB'(255);
        endcase
    endfunction

    // Shift the selected lanes to the top, then back down arithmetically or logically.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input logic [1:0] sz,
                                                 input logic sx);
        int                       sh;
        logic signed [DATA_W-1:0] sv;
        sh = DATA_W - (8 << sz);
        if (sh < 0) sh = 0;
        sv = $signed(v << sh);
        if (sx) extend = sv >>> sh;
        else    extend = (v << sh) >> sh;
    endfunction

    assign idx         = bus.address[IW+LB-1:LB];
    assign ofs         = bus.address[LB-1:0];
    assign unused_addr = ^bus.address[ADDR_W-1:IW+LB];

    assign nbytes     = 4'd1 << bus.size;
    assign misaligned = (4'(ofs) & (nbytes - 4'd1)) != 4'd0;
    assign illegal    = (bus.size == 2'b11) && (DATA_W == 32);
    assign bad        = misaligned || illegal;
    assign collide    = bus.memread && bus.memwrite;

    assign do_wr = ready_q && bus.memwrite && !bad;
    assign do_rd = ready_q && bus.memread && !bus.memwrite && !bad;
    assign rej   = ready_q && (((bus.memread || bus.memwrite) && bad) || collide);

    assign be       = lane_mask(bus.size) << ofs;
    assign wdata_sh = bus.writedata << {ofs, 3'b000};
    assign rdata_p0 = extend(mem[idx] >> {ofs, 3'b000}, bus.size, bus.sign_ext);

    // Stage p0 -> p1: control state, load result and status strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_RST;
            clr_ptr  <= '0;
            ready_q  <= 1'b0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= do_rd;
            err_p1 <= rej;
            if (do_rd) rdata_p1 <= rdata_p0;
            case (state)
                S_CLEAR: begin
                    if (clr_ptr == IW'(DEPTH - 1)) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (do_wr) begin
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
    end

    assign bus.readdata = rdata_p1;
    assign bus.rvalid   = vld_p1;
    assign bus.err      = err_p1;
    assign bus.ready    = ready_q;
endmodule

// File: tb/tb_datamemory_sized.sv
// Directed bench for datamemory_sized (DATA_W=32, DEPTH=16, clear sweep on).
`timescale 1ns/1ps
module tb_datamemory_sized;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    int   e;

    datamemory_sized_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    datamemory_sized #(
        .DATA_W(32), .DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                         input string tag);
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b1;
        bus.size      = sz;
        bus.address   = a;
        bus.writedata = d;
        @(posedge clk); #1;
        idle();
        chk({tag, "_err"}, bus.err, 1'b0);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                        input logic [31:0] exp, input string tag);
        bus.memread  = 1'b1;
        bus.memwrite = 1'b0;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.address  = a;
        @(posedge clk); #1;
        idle();
        chk({tag, "_rv"}, bus.rvalid, 1'b1);
        chk(tag, bus.readdata, exp);
    endtask

    task automatic reject(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] d, input string tag);
        bus.memread   = rd;
        bus.memwrite  = wr;
        bus.size      = sz;
        bus.sign_ext  = 1'b0;
        bus.address   = a;
        bus.writedata = d;
        @(posedge clk); #1;
        idle();
        chk({tag, "_err"}, bus.err, 1'b1);
        chk({tag, "_rv"}, bus.rvalid, 1'b0);
    endtask

    // Counts edges until ready, driving requests that must be ignored meanwhile.
    task automatic sweep_count(output int edges);
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k[0]) begin
                bus.memread = 1'b1; bus.memwrite = 1'b0;
                bus.size = 2'd2; bus.address = 32'h0;
            end else begin
                bus.memread = 1'b0; bus.memwrite = 1'b1;
                bus.size = 2'd1; bus.address = 32'h3; bus.writedata = 32'hFFFF;
            end
            @(posedge clk); #1;
            chk("sweep_err", bus.err, 1'b0);
            chk("sweep_rv", bus.rvalid, 1'b0);
            if (bus.ready) begin
                edges = k;
                break;
            end
        end
        idle();
        if (edges == 0) edges = 41;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.memread = 1'b0; bus.memwrite = 1'b0; bus.size = 2'd2;
        bus.sign_ext = 1'b0; bus.address = '0; bus.writedata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_ready", bus.ready, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        @(negedge clk) rst = 1'b1;
        sweep_count(e);
        chk("init_sweep_len", e, 16);

        store(32'h0, 2'd2, 32'd123, "st123");
        load(32'h0, 2'd2, 1'b0, 32'd123, "ld123");
        for (int i = 0; i < 10; i++) store(32'(4 * i), 2'd2, 32'(i), "st_loop");
        for (int i = 0; i < 10; i++) load(32'(4 * i), 2'd2, 1'b0, 32'(i), "ld_loop");

        store(32'h8, 2'd2, 32'h11223344, "st_w8");
        store(32'hA, 2'd0, 32'h000000F0, "st_bA");
        load(32'h8, 2'd2, 1'b0, 32'h11F03344, "ld_w8");
        @(posedge clk); #1;
        chk("rv_one_cycle", bus.rvalid, 1'b0);
        chk("rd_hold", bus.readdata, 32'h11F03344);
        load(32'hA, 2'd0, 1'b1, 32'hFFFFFFF0, "ld_sbA");
        load(32'hA, 2'd0, 1'b0, 32'h000000F0, "ld_ubA");
        load(32'hA, 2'd1, 1'b1, 32'h000011F0, "ld_shA");
        store(32'hE, 2'd1, 32'h00008001, "st_hE");
        load(32'hE, 2'd1, 1'b1, 32'hFFFF8001, "ld_shE");
        load(32'hC, 2'd2, 1'b0, 32'h80010003, "ld_wC");

        store(32'h0, 2'd2, 32'hCAFEBABE, "st_w0");
        reject(1'b0, 1'b1, 32'h3, 2'd1, 32'hFFFF, "rej_mis_st");
        reject(1'b0, 1'b1, 32'h0, 2'd3, 32'h12345678, "rej_sz11_st");
        reject(1'b1, 1'b0, 32'h0, 2'd3, 32'h0, "rej_sz11_ld");
        reject(1'b1, 1'b0, 32'h2, 2'd2, 32'h0, "rej_mis_ld");
        reject(1'b1, 1'b1, 32'h4, 2'd2, 32'd7, "rej_coll");
        load(32'h0, 2'd2, 1'b0, 32'hCAFEBABE, "w0_intact");
        load(32'h4, 2'd2, 1'b0, 32'd7, "coll_wr");

        store(32'h40, 2'd2, 32'hAA, "st_wrap");
        load(32'h0, 2'd2, 1'b0, 32'hAA, "ld_wrap");

        bus.memread = 1'b1; bus.size = 2'd2; bus.sign_ext = 1'b0; bus.address = 32'h0;
        @(posedge clk); #1;
        chk("b2b0_rv", bus.rvalid, 1'b1);
        chk("b2b0", bus.readdata, 32'hAA);
        bus.address = 32'h4;
        @(posedge clk); #1;
        idle();
        chk("b2b1_rv", bus.rvalid, 1'b1);
        chk("b2b1", bus.readdata, 32'd7);

        for (int i = 0; i < 16; i++) store(32'(4 * i), 2'd2, 32'hA5A50000 | 32'(i), "st_junk");
        load(32'h14, 2'd2, 1'b0, 32'hA5A50005, "ld_junk");
        #2 rst = 1'b0;
        #1;
        chk("rstrd_rv", bus.rvalid, 1'b0);
        chk("rstrd_rd", bus.readdata, 32'h0);
        chk("rstrd_ready", bus.ready, 1'b0);
        @(negedge clk) rst = 1'b1;
        sweep_count(e);
        chk("clr_sweep_len", e, 16);
        for (int i = 0; i < 16; i++) load(32'(4 * i), 2'd2, 1'b0, 32'h0, "ld_clr");

        store(32'h8, 2'd2, 32'h5555AAAA, "st_pre");
        load(32'h8, 2'd2, 1'b0, 32'h5555AAAA, "ld_pre");
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rd", bus.readdata, 32'h0);
        chk("mid_rv", bus.rvalid, 1'b0);
        chk("mid_ready", bus.ready, 1'b0);
        @(negedge clk) rst = 1'b1;
        sweep_count(e);
        chk("mid_sweep_len", e, 16);
        load(32'h8, 2'd2, 1'b0, 32'h0, "ld_mid_clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/datamemory_sized.md
# datamemory_sized

Parameterised data memory for the KGP-RISC datapath, the successor to the fixed 32-bit word-only data memory. It adds configurable width and depth, byte/halfword/word/doubleword access with sign or zero extension, a registered read with a valid strobe, misalignment detection, and a hardware clear sweep after reset. It sits between the ALU address output and the write-back mux.

## Interface
Parameters:
- DATA_W, 32: word width in bits; legal values 32 or 64.
- DEPTH, 1024: number of words; power of two, at least 2.
- ADDR_W, 32: byte-address width.
- CLEAR_ON_RESET, 1: 1 means zero every word after reset; 0 means skip the sweep.

Derived values: LB = log2(DATA_W/8) and IW = log2(DEPTH).

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous and active-low.
- memread, input, 1: read request.
- memwrite, input, 1: write request.
- size, input, 2: access size. 00 is byte, 01 is halfword, 10 is word (32-bit), 11 is doubleword (legal only when DATA_W=64).
- sign_ext, input, 1: on loads, 1 means sign-extend and 0 means zero-extend.
- address, input, ADDR_W: byte address.
- writedata, input, DATA_W: store data, taken from the low bits.
- readdata, output, DATA_W: registered load result.
- rvalid, output, 1: one-cycle pulse when readdata is updated.
- ready, output, 1: block accepts requests.
- err, output, 1: one-cycle pulse on a rejected request.

## Operation
- Word index is address[IW+LB-1:LB]. Address bits at and above IW+LB are ignored, so addresses wrap modulo DEPTH words.
- Lane offset is address[LB-1:0]. Access width is nbytes = 2^size.
- A request is accepted only in a cycle where ready=1. While ready=0, requests are dropped silently: no err, no rvalid.

Rejection rules. A rejected request changes no memory and raises err for one cycle. A rejected read also gives rvalid=0.
- Misaligned: the offset is not a multiple of nbytes.
- Illegal size: size=11 with DATA_W=32.
- Collision: memread=1 and memwrite=1 together. The write is still performed if it is aligned and legal; the read is dropped and err is raised.

Writes:
- Only the nbytes lanes starting at the offset are updated.
- The lanes are loaded from writedata[8*nbytes-1:0]; all other lanes are unchanged.

Reads:
- The selected lanes are shifted down to bit 0.
- The upper bits are filled with copies of the top selected bit when sign_ext=1, else with zeros.
- When nbytes equals DATA_W/8, sign_ext has no effect.

State machine:
- CLEAR: entered while rst=0.
  - A clear pointer starts at 0 and zeroes one word per cycle.
  - After word DEPTH-1 is zeroed, the state moves to IDLE, so the sweep takes exactly DEPTH cycles after reset release.
  - With CLEAR_ON_RESET=0, the state goes straight to IDLE at reset.
- IDLE: ready=1; requests are serviced as above.
- Reset asserted mid-sweep restarts the sweep from word 0.
- Reset asserted mid-read clears rvalid immediately; the pending result is lost.

## Timing
- Reset values (asynchronous, while rst=0): readdata=0, rvalid=0, err=0, ready=0, clear pointer=0, state=CLEAR.
- With CLEAR_ON_RESET=0 the reset state is IDLE, and ready=1 from the first edge after release.
- Read latency is 1. A read accepted at edge N gives readdata and rvalid=1 after edge N, held for one cycle. readdata then holds its value until the next accepted read.
- err follows the same timing as rvalid: asserted after the edge that rejects the request, for one cycle.
- Writes commit at the accepting edge. A read of the same address in the next cycle returns the new data; there is no forwarding hazard.
- Back-to-back accepted reads give rvalid=1 on consecutive cycles.
- ready rises after the edge that zeroes word DEPTH-1, i.e. DEPTH edges after rst rises.

## Test plan
- Clear sweep (DEPTH=16):
  - Stimulus: preload garbage, pulse rst low, release.
  - Required: ready=0 for exactly 16 edges, then 1; word reads at 0x0 to 0x3C all return 0.
- Word store/load:
  - Stimulus: store word 123 at 0x0, then load word at 0x0 in the next cycle.
  - Required: readdata=123 with rvalid=1 one cycle after the load; loop addresses 0..9 words storing i, read back, expect i.
- Sized access (DATA_W=32):
  - Stimulus: store word 0x11223344 at 0x8, then store byte 0xF0 at 0xA.
  - Required: word load at 0x8 returns 0x11F03344.
  - Required: signed byte load at 0xA returns 0xFFFFFFF0; unsigned returns 0x000000F0.
  - Required: signed halfword load at 0xA returns 0x000011F0.
- Rejections:
  - Stimulus: halfword store at 0x3; size=11 with DATA_W=32; simultaneous memread and memwrite at 0x4 with data 7.
  - Required: err pulses each time and rvalid stays 0; memory at 0x0 is unchanged; word 0x4 reads back 7.
- Wrap-around (DEPTH=16):
  - Stimulus: store 0xAA at address 0x40.
  - Required: a load from 0x0 returns 0xAA.
- Reset mid-sweep:
  - Stimulus: assert rst at sweep cycle 5, release.
  - Required: readdata, rvalid and ready are 0 immediately; ready returns exactly 16 edges after release; requests made while ready=0 produce neither err nor rvalid.
